// File: rtl/eep_lsu.sv
// Load/store initiator for the eep data path: one request at a time, drives the
// dram ports and writes load results back through the regfile write port.
module eep_lsu #(
  parameter  int REG_DEPTH      = 8,
  parameter  int REG_WIDTH      = 16,
  parameter  int RD_LAT         = 1,
  localparam int REG_ADDR_WIDTH = $clog2(REG_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_store,
  input  logic [REG_WIDTH-1:0]      req_addr,
  input  logic [REG_WIDTH-1:0]      req_wdata,
  input  logic [REG_ADDR_WIDTH-1:0] req_rd,
  output logic                      dram_we,
  output logic [REG_WIDTH-1:0]      dram_wt_ad,
  output logic [REG_WIDTH-1:0]      dram_in,
  output logic [REG_WIDTH-1:0]      dram_rd_ad,
  input  logic [REG_WIDTH-1:0]      dram_out,
  output logic                      rf_wen,
  output logic [REG_ADDR_WIDTH-1:0] rf_ad,
  output logic [REG_WIDTH-1:0]      rf_din,
  output logic                      ld_done
);

  generate
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $fatal(1, "eep_lsu: RD_LAT must be in 1..4");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_STORE     = 2'd1,
    ST_LOAD_WAIT = 2'd2,
    ST_WB        = 2'd3
  } state_t;

  state_t                    state_r;
  state_t                    state_s;
  logic [2:0]                cnt_r;
  logic [2:0]                cnt_s;
  logic [REG_ADDR_WIDTH-1:0] rd_r;
  logic [REG_ADDR_WIDTH-1:0] rd_s;
  logic                      accept_s;
  logic                      dram_we_s;
  logic [REG_WIDTH-1:0]      dram_wt_ad_s;
  logic [REG_WIDTH-1:0]      dram_in_s;
  logic [REG_WIDTH-1:0]      dram_rd_ad_s;
  logic                      rf_wen_s;
  logic [REG_ADDR_WIDTH-1:0] rf_ad_s;
  logic [REG_WIDTH-1:0]      rf_din_s;
  logic                      ld_done_s;

  // Ready is gated by reset so nothing can be accepted while rst_n is low.
  assign req_ready = rst_n && ((state_r == ST_IDLE) || (state_r == ST_STORE));
  assign accept_s  = req_valid && req_ready;

  // Next-state and next-output decode; all outputs are registered below.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    rd_s         = rd_r;
    dram_we_s    = 1'b0;
    dram_wt_ad_s = dram_wt_ad;
    dram_in_s    = dram_in;
    dram_rd_ad_s = dram_rd_ad;
    rf_wen_s     = 1'b0;
    rf_ad_s      = rf_ad;
    rf_din_s     = rf_din;
    ld_done_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_STORE: begin
        if (accept_s) begin
          if (req_store) begin
            state_s      = ST_STORE;
            dram_we_s    = 1'b1;
            dram_wt_ad_s = req_addr;
            dram_in_s    = req_wdata;
          end else begin
            state_s      = ST_LOAD_WAIT;
            cnt_s        = 3'(RD_LAT);
            dram_rd_ad_s = req_addr;
            rd_s         = req_rd;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD_WAIT: begin
        cnt_s = cnt_r - 3'd1;
        // Last wait cycle: dram_out is valid now and lands directly in rf_din.
        if (cnt_r == 3'd1) begin
          state_s   = ST_WB;
          rf_wen_s  = 1'b1;
          rf_ad_s   = rd_r;
          rf_din_s  = dram_out;
          ld_done_s = 1'b1;
        end else begin
          state_s = ST_LOAD_WAIT;
        end
      end
      ST_WB: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 3'd0;
      rd_r       <= '0;
      dram_we    <= 1'b0;
      dram_wt_ad <= '0;
      dram_in    <= '0;
      dram_rd_ad <= '0;
      rf_wen     <= 1'b0;
      rf_ad      <= '0;
      rf_din     <= '0;
      ld_done    <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      rd_r       <= rd_s;
      dram_we    <= dram_we_s;
      dram_wt_ad <= dram_wt_ad_s;
      dram_in    <= dram_in_s;
      dram_rd_ad <= dram_rd_ad_s;
      rf_wen     <= rf_wen_s;
      rf_ad      <= rf_ad_s;
      rf_din     <= rf_din_s;
      ld_done    <= ld_done_s;
    end
  end

endmodule
